// File: rtl/ks_adder_pipe_if.sv
// Streaming add/sub request and result channel for ks_adder_pipe.
interface ks_adder_pipe_if #(
   parameter int unsigned WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_ci;
   logic             in_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_s;
   logic             out_co;
   logic             out_ovf;

   // Producer/consumer side
   modport master (
      output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
      input  in_ready, out_valid, out_s, out_co, out_ovf
   );

   // Adder side
   modport slave (
      input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
      output in_ready, out_valid, out_s, out_co, out_ovf
   );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and global stall.
// Register 0 holds G/P pre-processing; registers 1..STAGES-1 each hold the result of a
// slice of the prefix levels. Final carries, sum XOR and flags are combinational.
module ks_adder_pipe #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input logic            clk,
   input logic            rst_n,
   ks_adder_pipe_if.slave bus
);

   localparam int unsigned Levels    = $clog2(WIDTH);
   localparam int unsigned PfxStages = STAGES - 1;
   localparam int unsigned Div       = (PfxStages == 0) ? 1 : PfxStages;
   localparam int unsigned Base      = Levels / Div;
   localparam int unsigned Extra     = Levels % Div;
   // With a single register every prefix level sits after it.
   localparam int unsigned FinalLo   = (PfxStages == 0) ? 0 : Levels;
   localparam int unsigned Last      = STAGES - 1;

   // First prefix level handled by prefix stage r; earlier stages take the extra level.
   function automatic int unsigned lvl_start(int unsigned r);
      return r * Base + ((r < Extra) ? r : Extra);
   endfunction

   // Apply Kogge-Stone levels [lo, hi) to a G/P vector pair; returns {g, p}.
   function automatic logic [2*WIDTH-1:0] ks_apply(logic [WIDTH-1:0] g_in,
                                                  logic [WIDTH-1:0] p_in,
                                                  int unsigned lo, int unsigned hi);
      logic [WIDTH-1:0] g, p, gn, pn;
      g = g_in;
      p = p_in;
      for (int unsigned l = 0; l < Levels; l++) begin
         if (l >= lo && l < hi) begin
            gn = g;
            pn = p;
            for (int unsigned i = (1 << l); i < WIDTH; i++) begin
               gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
               pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
         end
      end
      return {g, p};
   endfunction

   logic [WIDTH-1:0] g_q [STAGES];
   logic [WIDTH-1:0] g_d [STAGES];
   logic [WIDTH-1:0] p_q [STAGES];
   logic [WIDTH-1:0] p_d [STAGES];
   logic [WIDTH-1:0] x_q [STAGES];   // bitwise a ^ b', kept for the sum XOR
   logic [WIDTH-1:0] x_d [STAGES];
   logic             cin_q [STAGES];
   logic             cin_d [STAGES];
   logic             am_q [STAGES];
   logic             am_d [STAGES];
   logic             bm_q [STAGES];
   logic             bm_d [STAGES];
   logic             vld_q [STAGES];
   logic             vld_d [STAGES];

   logic             en;
   logic             accept;
   logic [WIDTH-1:0] b_eff;
   logic [2*WIDTH-1:0] pfx_fin;
   logic [WIDTH-1:0] g_fin, p_fin;
   logic [WIDTH:0]   c;

   assign en           = !vld_q[Last] || bus.out_ready;
   assign bus.in_ready = en && rst_n;
   assign accept       = bus.in_valid && bus.in_ready;
   assign b_eff        = bus.in_sub ? ~bus.in_b : bus.in_b;

   // Next-state for every stage: pre-processing into stage 0, prefix slices downstream.
   always_comb begin
      for (int unsigned s = 0; s < STAGES; s++) begin
         g_d[s]   = g_q[s];
         p_d[s]   = p_q[s];
         x_d[s]   = x_q[s];
         cin_d[s] = cin_q[s];
         am_d[s]  = am_q[s];
         bm_d[s]  = bm_q[s];
         vld_d[s] = vld_q[s];
      end
      vld_d[0] = accept;
      // Bubbles keep the old stage-0 data so nothing undefined enters the pipe.
      if (accept) begin
         g_d[0]   = bus.in_a & b_eff;
         p_d[0]   = bus.in_a ^ b_eff;
         x_d[0]   = bus.in_a ^ b_eff;
         cin_d[0] = bus.in_sub ? !bus.in_ci : bus.in_ci;
         am_d[0]  = bus.in_a[WIDTH-1];
         bm_d[0]  = b_eff[WIDTH-1];
      end
      for (int unsigned s = 1; s < STAGES; s++) begin
         {g_d[s], p_d[s]} = ks_apply(g_q[s-1], p_q[s-1], lvl_start(s - 1), lvl_start(s));
         x_d[s]   = x_q[s-1];
         cin_d[s] = cin_q[s-1];
         am_d[s]  = am_q[s-1];
         bm_d[s]  = bm_q[s-1];
         vld_d[s] = vld_q[s-1];
      end
   end

   // Pipeline registers: synchronous clear, whole pipe holds when en is low.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            g_q[s]   <= '0;
            p_q[s]   <= '0;
            x_q[s]   <= '0;
            cin_q[s] <= 1'b0;
            am_q[s]  <= 1'b0;
            bm_q[s]  <= 1'b0;
            vld_q[s] <= 1'b0;
         end
      end else if (en) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            g_q[s]   <= g_d[s];
            p_q[s]   <= p_d[s];
            x_q[s]   <= x_d[s];
            cin_q[s] <= cin_d[s];
            am_q[s]  <= am_d[s];
            bm_q[s]  <= bm_d[s];
            vld_q[s] <= vld_d[s];
         end
      end
   end

   assign pfx_fin        = ks_apply(g_q[Last], p_q[Last], FinalLo, Levels);
   assign {g_fin, p_fin} = pfx_fin;

   // Fold carry-in into the group generates, then form sum and flags.
   always_comb begin
      c    = '0;
      c[0] = cin_q[Last];
      for (int unsigned i = 0; i < WIDTH; i++) begin
         c[i+1] = g_fin[i] | (p_fin[i] & cin_q[Last]);
      end
   end

   assign bus.out_valid = vld_q[Last];
   assign bus.out_s     = x_q[Last] ^ c[WIDTH-1:0];
   assign bus.out_co    = c[WIDTH];
   assign bus.out_ovf   = (am_q[Last] == bm_q[Last]) && (bus.out_s[WIDTH-1] != am_q[Last]);

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe (WIDTH=16, STAGES=3).
module tb_ks_adder_pipe;
   localparam int unsigned W  = 16;
   localparam int unsigned ST = 3;

   typedef struct {
      logic [W+1:0] res;      // {co, ovf, s}
      bit           chk_lat;
      int unsigned  cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ks_adder_pipe_if #(.WIDTH(W)) bif ();

   ks_adder_pipe #(.WIDTH(W), .STAGES(ST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_out = 0;
   int unsigned cyc = 0;
   int unsigned last_out_cyc = 0;
   int unsigned run_len = 0;

   always @(posedge clk) cyc++;

   // Monitor: pop and compare on every output handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bif.out_valid && bif.out_ready) begin
         if (last_out_cyc + 1 == cyc) run_len++;
         else run_len = 1;
         last_out_cyc = cyc;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output got=%h req=none", {bif.out_co, bif.out_ovf, bif.out_s});
         end else begin
            e = sb.pop_front();
            n_out++;
            if ({bif.out_co, bif.out_ovf, bif.out_s} !== e.res) begin
               n_err++;
               $display("FAIL result got={co,ovf,s}=%h req=%h", {bif.out_co, bif.out_ovf, bif.out_s},
                        e.res);
            end
            if (e.chk_lat && cyc != e.cyc) begin
               n_err++;
               $display("FAIL latency got_cycle=%0d req_cycle=%0d", cyc, e.cyc);
            end
         end
      end
   end

   function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sub);
      logic [W-1:0] bp;
      logic [W:0]   t;
      logic         ovf;
      bp  = sub ? ~b : b;
      t   = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, (sub ? !ci : ci)};
      ovf = (a[W-1] == bp[W-1]) && (t[W-1] != a[W-1]);
      return {t[W], ovf, t[W-1:0]};
   endfunction

   task automatic chk(string name, logic [63:0] got, logic [63:0] req);
      if (got !== req) begin
         n_err++;
         $display("FAIL %s got=%h req=%h", name, got, req);
      end
   endtask

   // Present one vector until accepted; expected response pushed at acceptance.
   task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic ci, logic sub,
                       logic [W+1:0] res, bit chk_lat);
      bit          acc = 1'b0;
      int unsigned waited = 0;
      exp_t        e;
      bif.in_a     = a;
      bif.in_b     = b;
      bif.in_ci    = ci;
      bif.in_sub   = sub;
      bif.in_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         if (bif.in_ready) begin
            e.res     = res;
            e.chk_lat = chk_lat;
            e.cyc     = cyc + ST;
            sb.push_back(e);
            n_vec++;
            acc = 1'b1;
         end
         @(posedge clk);
         #1;
         waited++;
         if (!acc && waited > 200) begin
            n_err++;
            $display("FAIL accept_timeout got=not_accepted req=accepted");
            break;
         end
      end
      bif.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      bif.in_valid  = 1'b1;
      bif.in_a      = '0;
      bif.in_b      = '0;
      bif.in_ci     = 1'b0;
      bif.in_sub    = 1'b0;
      bif.out_ready = 1'b1;

      // Reset held with in_valid high
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_in_ready", 64'(bif.in_ready), 64'd0);
         chk("rst_out_valid", 64'(bif.out_valid), 64'd0);
         chk("rst_out_s", 64'(bif.out_s), 64'd0);
         chk("rst_out_co", 64'(bif.out_co), 64'd0);
         chk("rst_out_ovf", 64'(bif.out_ovf), 64'd0);
      end
      @(posedge clk);
      #1;
      bif.in_valid = 1'b0;
      rst_n = 1'b1;

      // Isolated vectors with latency check
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b1);
      wait_drain();
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, 1'b1);
      wait_drain();
      send(16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 1'b1);
      wait_drain();

      // Back-to-back directed table
      send(16'h0007, 16'h0005, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0002}, 1'b0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 1'b0);
      send(16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556}, 1'b0);
      send(16'h0005, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFF}, 1'b0);
      send(16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000}, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, {1'b1, 1'b0, 16'hFFFF}, 1'b0);
      send(16'h0000, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000}, 1'b0);
      wait_drain();

      // 100 back-to-back, results must emerge on consecutive cycles
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0] a, b;
         a = W'(i * 16'h0A3B + 16'h1111);
         b = W'(i * 16'h3C07);
         send(a, b, i[0], i[1], model(a, b, i[0], i[1]), 1'b0);
      end
      wait_drain();
      chk("consecutive_run", 64'(run_len >= 100), 64'd1);

      // Fill pipe with out_ready low, hold 5 cycles, release
      bif.out_ready = 1'b0;
      send(16'h0102, 16'h0304, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0406}, 1'b0);
      send(16'hF000, 16'h1000, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000}, 1'b0);
      send(16'h4000, 16'h4000, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000}, 1'b0);
      bif.in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(bif.in_ready), 64'd0);
         chk("stall_out_valid", 64'(bif.out_valid), 64'd1);
         chk("stall_hold", 64'({bif.out_co, bif.out_ovf, bif.out_s}), 64'({1'b0, 1'b0, 16'h0406}));
      end
      @(posedge clk);
      #1;
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      wait_drain();

      // Reset mid-stream discards in-flight work
      send(16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333}, 1'b0);
      send(16'h2222, 16'h3333, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 1'b0);
      rst_n = 1'b0;
      sb.delete();
      repeat (2) begin
         @(negedge clk);
         chk("midrst_out_valid", 64'(bif.out_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, 1'b1);
      wait_drain();

      // Random backpressure and input gaps
      fork
         begin
            for (int i = 0; i < 150; i++) begin
               logic [W-1:0] a, b;
               logic         ci, sub;
               a   = W'($urandom);
               b   = W'($urandom);
               ci  = 1'($urandom);
               sub = 1'($urandom);
               send(a, b, ci, sub, model(a, b, ci, sub), 1'b0);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
         end
         begin
            for (int i = 0; i < 600; i++) begin
               @(posedge clk);
               #1;
               bif.out_ready = 1'($urandom);
            end
            bif.out_ready = 1'b1;
         end
      join
      bif.out_ready = 1'b1;
      wait_drain();
      chk("out_count", 64'(n_out), 64'(n_vec - 2));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
